// File: rtl/cpu_lsu.sv
// cpu_lsu: load/store unit between the Q4 memory stage and a
// request/grant/response data-memory bus. One access in flight at a time.
// Handshake: the bus accepts a request in the cycle o_bus_req=1 and
// i_bus_gnt=1, and returns exactly one i_bus_rvalid in a later cycle.
// Misaligned or illegal-size operations finish at once with o_exc and
// generate no bus traffic.
module cpu_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_stall,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_exc,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [3:0]        o_bus_wstrb,
  output logic [31:0]       o_bus_wdata,
  input  logic              i_bus_gnt,
  input  logic              i_bus_rvalid,
  input  logic [31:0]       i_bus_rdata,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // Operation attributes captured at acceptance, used to shape load data.
  logic       cap_we;
  logic [2:0] cap_f3;
  logic [1:0] cap_off;

  logic [1:0]  req_off;
  logic        req_legal;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic [31:0] rd_shift;
  logic [31:0] load_data;

  assign req_off     = i_req_addr[1:0];
  assign o_dbg_state = state_q;

  // Legality of the incoming operation from size and byte offset.
  always_comb begin
    req_legal = 1'b0;
    if (i_req_we) begin
      case (i_req_funct3)
        3'd0:    req_legal = 1'b1;
        3'd1:    req_legal = (req_off[0] == 1'b0);
        3'd2:    req_legal = (req_off == 2'b00);
        default: req_legal = 1'b0;
      endcase
    end else begin
      case (i_req_funct3)
        3'd0, 3'd4: req_legal = 1'b1;
        3'd1, 3'd5: req_legal = (req_off[0] == 1'b0);
        3'd2:       req_legal = (req_off == 2'b00);
        default:    req_legal = 1'b0;
      endcase
    end
  end

  // Byte strobes and lane-replicated write data for stores; zero for loads.
  always_comb begin
    req_wstrb = 4'b0000;
    req_wdata = 32'h0;
    if (i_req_we) begin
      case (i_req_funct3[1:0])
        2'd0: begin
          req_wstrb = 4'b0001 << req_off;
          req_wdata = {4{i_req_wdata[7:0]}};
        end
        2'd1: begin
          req_wstrb = 4'b0011 << req_off;
          req_wdata = {2{i_req_wdata[15:0]}};
        end
        default: begin
          req_wstrb = 4'b1111;
          req_wdata = i_req_wdata;
        end
      endcase
    end
  end

  // Load lane extraction and extension using the captured offset.
  always_comb begin
    rd_shift  = i_bus_rdata >> {cap_off, 3'b000};
    load_data = 32'h0;
    if (!cap_we) begin
      case (cap_f3)
        3'd0:    load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
        3'd1:    load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
        3'd4:    load_data = {24'h0, rd_shift[7:0]};
        3'd5:    load_data = {16'h0, rd_shift[15:0]};
        default: load_data = i_bus_rdata;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; grant only counts in REQ, rvalid only in WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          state_d = req_legal ? S_REQ : S_RESP;
        end
      end
      S_REQ: begin
        if (i_bus_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_bus_rvalid) begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pipeline hold: combinational so Q4 freezes in the accepting cycle.
  always_comb begin
    o_stall = ((state_q == S_IDLE) && i_req_valid) ||
              (state_q == S_REQ) || (state_q == S_WAIT);
  end

  // Registered bus and response outputs plus captured operation fields.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= 32'h0;
      o_exc       <= 1'b0;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wstrb <= 4'b0000;
      o_bus_wdata <= 32'h0;
      cap_we      <= 1'b0;
      cap_f3      <= 3'd0;
      cap_off     <= 2'd0;
    end else begin
      o_rsp_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_req_valid) begin
            cap_we  <= i_req_we;
            cap_f3  <= i_req_funct3;
            cap_off <= req_off;
            if (req_legal) begin
              o_bus_req   <= 1'b1;
              o_bus_we    <= i_req_we;
              o_bus_addr  <= {i_req_addr[ADDR_W-1:2], 2'b00};
              o_bus_wstrb <= req_wstrb;
              o_bus_wdata <= req_wdata;
            end else begin
              o_rsp_valid <= 1'b1;
              o_exc       <= 1'b1;
              o_rsp_rdata <= 32'h0;
            end
          end
        end
        S_REQ: begin
          if (i_bus_gnt) begin
            o_bus_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (i_bus_rvalid) begin
            o_rsp_valid <= 1'b1;
            o_exc       <= 1'b0;
            o_rsp_rdata <= load_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/cpu_lsu.md
# cpu_lsu

Load/store unit between the Q4 memory stage of the 5-stage RISC-V pipeline and a request/grant/response data-memory bus. It takes one Q4 memory operation at a time and issues a word-aligned bus access with byte strobes and lane-replicated write data. It returns sign- or zero-extended load data and stalls the pipeline until the access completes. Misaligned accesses and illegal sizes complete immediately with an exception flag and no bus traffic.

## Interface
- ADDR_W, 32, byte address width; bus address is word-aligned.
- i_clk  in  1  clock.
- i_rst  in  1  reset; one clock; synchronous, active-high.
- i_req_valid  in  1  Q4 holds a load/store; held stable while o_stall=1.
- i_req_we  in  1  1=store, 0=load.
- i_req_funct3  in  3  RISC-V funct3. Loads: LB=0, LH=1, LW=2, LBU=4, LHU=5. Stores: SB=0, SH=1, SW=2.
- i_req_addr  in  ADDR_W  byte address (ALU result).
- i_req_wdata  in  32  store data (forwarded rs2).
- o_stall  out  1  hold IF..Q4 this cycle.
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_rsp_rdata  out  32  extended load data; 0 for stores and exceptions.
- o_exc  out  1  misaligned or illegal size; qualified by o_rsp_valid.
- o_bus_req  out  1  bus request.
- o_bus_we  out  1  bus write.
- o_bus_addr  out  ADDR_W  {addr[ADDR_W-1:2], 2'b00}.
- o_bus_wstrb  out  4  byte enables; 0 for loads.
- o_bus_wdata  out  32  lane-replicated store data.
- i_bus_gnt  in  1  request accepted this cycle.
- i_bus_rvalid  in  1  response for the granted access (loads and stores).
- i_bus_rdata  in  32  read word.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE, i_req_valid=1, legal: capture we/funct3/addr[1:0]; register bus outputs; go to REQ.
- IDLE, i_req_valid=1, illegal: capture the exception; go to RESP; no bus access.
- Illegal conditions:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
  - Load funct3 in {3,6,7}.
  - Store funct3 ≥3.
- REQ: o_bus_req=1. addr/we/wstrb/wdata stay constant until i_bus_gnt=1, then go to WAIT.
- WAIT: on i_bus_rvalid, register the extended data and go to RESP.
- RESP: o_rsp_valid=1, return to IDLE. i_req_valid is ignored here because it is the completing request; the pipeline advances at the end of this cycle.
- Strobes, by offset o=addr[1:0]:
  - SB: 4'b0001<<o.
  - SH: 4'b0011<<o.
  - SW: 4'b1111.
- Write data:
  - SB: wdata[7:0] replicated ×4.
  - SH: wdata[15:0] replicated ×2.
  - SW: unchanged.
- Load extraction uses the captured offset:
  - Byte: rdata[8*o+:8].
  - Half: rdata[8*o+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- o_stall = (state==IDLE & i_req_valid) | state==REQ | state==WAIT. It is combinational; all other outputs are registered.
- i_bus_gnt outside REQ is ignored; i_bus_rvalid outside WAIT is ignored.
- o_rsp_rdata and o_exc are meaningful only with o_rsp_valid; they hold their value otherwise.

## Timing
- Reset: state=IDLE; all outputs 0.
- Reset mid-operation aborts the access; a later rvalid from it is ignored.
- Zero-wait bus (gnt with req, rvalid the cycle after gnt), request seen at cycle N:
  - N: IDLE, stall=1.
  - N+1: REQ, req=1, gnt=1, stall=1.
  - N+2: WAIT, rvalid=1, stall=1.
  - N+3: RESP, rsp_valid=1, stall=0.
- Each extra gnt wait cycle or rvalid wait cycle adds one cycle of stall and latency.
- Exception: N stall=1; N+1 RESP with rsp_valid=1, exc=1, rdata=0.
- A new request at N+4 at the earliest (back-to-back: IDLE accepts the cycle after RESP).
- The bus never asserts rvalid in the same cycle as gnt; such an rvalid is ignored.
- Throughput: 1 access per 4 cycles minimum.

## Test plan
- LW 0x100, gnt immediate, rvalid next cycle with 0xDEADBEEF -> o_bus_addr=0x100, wstrb=0, we=0; stall high N..N+2; rsp_valid at N+3 with rdata=0xDEADBEEF, exc=0.
- Bus word 0x80112233:
  - LB 0x103 -> 0xFFFFFF80.
  - LBU 0x103 -> 0x00000080.
  - LH 0x102 -> 0xFFFF8011.
  - LHU 0x102 -> 0x00008011.
  - LB 0x100 -> 0x00000033.
- Stores:
  - SB 0x201, wdata 0x000000AB -> addr=0x200, wstrb=4'b0010, wdata=0xABABABAB, we=1.
  - SH 0x202, wdata 0x00001234 -> wstrb=4'b1100, wdata=0x12341234.
  - Each store gives rsp_valid with rdata=0.
- LW 0x102, SH 0x203, load funct3=3 -> each: no o_bus_req ever; rsp_valid and exc at N+1; rdata=0; stall only at N.
- gnt held low 3 cycles, then rvalid 2 cycles after gnt -> bus outputs constant while req=1; rsp_valid at N+7; stall high N..N+6.
- i_rst pulsed in WAIT, rvalid arrives next cycle -> all outputs 0, no rsp_valid. A following LW 0x104 completes normally.
